alu_bist_scheduler: RTL and testbench
=====================================

ALU_BIST_SCHEDULER -- requirements
Module: alu_bist_scheduler

Interface
REQ-001 SHALL have parameter TEST_INTERVAL, default 65535, meaning idle cycles between periodic self-tests.
REQ-002 SHALL have parameter NUM_VEC, default 8, meaning test vectors per session (max 8).
REQ-003 SHALL have parameter MAX_RETRY, default 1, meaning re-runs allowed after a failing session before declaring a fault.
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 test_req  input  1  external on-demand test request, level, sampled in IDLE only.
REQ-007 stall_grant  input  1  execute stage frozen and yielded to test.
REQ-008 primary_res  input  32  primary ALU result for the current vector.
REQ-009 primary_carry  input  1  primary ALU carry for the current vector.
REQ-010 stall_req  output  1  request to freeze the execute stage.
REQ-011 test_en  output  1  primary ALU in test mode; execute result mux selects spare.
REQ-012 test_counter  output  3  current vector index.
REQ-013 use_spare  output  1  sticky; primary retired, spare permanently selected.
REQ-014 fault_flag  output  1  sticky hardware fault indication.
REQ-015 test_done  output  1  one-cycle pulse at the end of each passing or final-failing session.
REQ-016 fail_vec  output  3  index of the first mismatching vector of the last failing session.

Function
REQ-017 FSM states SHALL be IDLE, REQ, RUN, EVAL and FAULT.
REQ-018 IDLE: 16-bit timer increments each cycle; move to REQ when timer == TEST_INTERVAL or test_req == 1; the timer clears on leaving IDLE.
REQ-019 REQ: stall_req = 1; stay until stall_grant == 1, then go to RUN with test_counter = 0; there is no timeout.
REQ-020 RUN: stall_req = 1 and test_en = 1; test_counter increments by 1 per cycle from 0 to NUM_VEC-1.
REQ-021 RUN comparison: each cycle, {primary_carry, primary_res} SHALL be compared combinationally with the golden entry for test_counter.
REQ-022 Mismatch latch: the first mismatch in a session sets the internal mismatch bit and captures fail_vec.
REQ-023 RUN exit: after the vector NUM_VEC-1 compare, go to EVAL; the session is always completed even after a mismatch.
REQ-024 EVAL, no mismatch: pulse test_done, clear the retry count, return to IDLE; stall_req deasserts in the same cycle.
REQ-025 EVAL, mismatch with retry count < MAX_RETRY: increment the retry count and go to REQ directly without pulsing test_done.
REQ-026 EVAL, mismatch with retry count == MAX_RETRY: pulse test_done, set fault_flag = 1 and use_spare = 1, go to FAULT.
REQ-027 FAULT: terminal until reset; test_en = 0, stall_req = 0, timer frozen, test_req ignored.
REQ-028 If stall_grant drops during RUN, the session SHALL abort without a verdict and return to REQ with test_counter = 0 and the mismatch bit cleared; the retry count is unchanged.
REQ-029 If the timer expiry and test_req coincide, exactly one session SHALL start.
REQ-030 test_counter wrap-around: test_counter never wraps inside a session; it holds 0 outside RUN.

Reset
REQ-031 Assertion of rst (low) SHALL immediately force state IDLE, timer 0, test_counter 0, retry count 0 and mismatch bit 0.
REQ-032 Assertion of rst (low) SHALL immediately force all outputs to 0, including use_spare and fault_flag.
REQ-033 Reset in the middle of RUN SHALL abandon the session with no test_done pulse.
REQ-034 Reset deassertion SHALL be synchronized internally with a 2-flop synchronizer before release.

Structure
REQ-035 The FSM state encoding, the golden vector table (operands, ALU control and expected {carry, result} for each index) and the default parameter values SHALL live in a shared package, alu_bist_pkg.
REQ-036 The golden table SHALL be held in one sub-module, bist_golden_rom, which is combinational, indexed by test_counter and outputs a 33-bit expected value.
REQ-037 The operand and control generation driven into the ALU SHALL remain in the ALU; this block supplies only test_en and test_counter.

Verification
REQ-038 Scenario 1 (TEST_INTERVAL=15, stall_grant tied 1, correct ALU model) -> stall_req rises at cycle 16 after reset; test_en is high for 8 cycles; test_done pulses once; use_spare stays 0.
REQ-039 Scenario 2 (vector 3 result bit 0 stuck on both sessions) -> two sessions run; fail_vec = 3; fault_flag = use_spare = 1; no further stall_req afterwards.
REQ-040 Scenario 3 (mismatch on the first session only) -> the retry session passes; use_spare = 0; exactly one test_done pulse.
REQ-041 Scenario 4 (stall_grant low for 5 cycles after stall_req, then high) -> test_en rises the cycle after grant; dropping grant at test_counter = 4 restarts at 0 with no test_done.
REQ-042 Scenario 5 (test_req pulsed at the same cycle as timer expiry) -> one session only; the timer restarts from 0.
REQ-043 Scenario 6 (rst asserted at test_counter = 5) -> all outputs are 0 immediately; the next session starts TEST_INTERVAL+1 cycles after release.

Source files
------------

// File: rtl/alu_bist_pkg.sv
// Shared definitions for the ALU built-in self-test scheduler: FSM encoding,
// default parameters and the golden vector table.
package alu_bist_pkg;

  localparam int DEF_TEST_INTERVAL = 65535;
  localparam int DEF_NUM_VEC       = 8;
  localparam int DEF_MAX_RETRY     = 1;

  localparam int VEC_IDX_W = 3;
  localparam int TIMER_W   = 16;
  localparam int RES_W     = 33;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_RUN,
    ST_EVAL,
    ST_FAULT
  } bist_state_e;

  // ALU control codes driven by the ALU's own test operand generator.
  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR
  } alu_op_e;

  // expected = {carry, result}; for SUB the carry bit is the borrow (a < b).
  typedef struct packed {
    logic [31:0]      op_a;
    logic [31:0]      op_b;
    alu_op_e          op;
    logic [RES_W-1:0] expected;
  } golden_vec_t;

  localparam golden_vec_t GOLDEN_TABLE [0:7] = '{
    '{op_a: 32'h0000_0000, op_b: 32'h0000_0000, op: ALU_ADD, expected: 33'h0_0000_0000},
    '{op_a: 32'hFFFF_FFFF, op_b: 32'h0000_0001, op: ALU_ADD, expected: 33'h1_0000_0000},
    '{op_a: 32'h1234_5678, op_b: 32'h1111_1111, op: ALU_ADD, expected: 33'h0_2345_6789},
    '{op_a: 32'h0000_0005, op_b: 32'h0000_0003, op: ALU_SUB, expected: 33'h0_0000_0002},
    '{op_a: 32'h0000_0000, op_b: 32'h0000_0001, op: ALU_SUB, expected: 33'h1_FFFF_FFFF},
    '{op_a: 32'hF0F0_F0F0, op_b: 32'hFF00_FF00, op: ALU_AND, expected: 33'h0_F000_F000},
    '{op_a: 32'hAAAA_AAAA, op_b: 32'h5555_5555, op: ALU_OR,  expected: 33'h0_FFFF_FFFF},
    '{op_a: 32'hDEAD_BEEF, op_b: 32'hFFFF_0000, op: ALU_XOR, expected: 33'h0_2152_BEEF}
  };

endpackage

// File: rtl/bist_golden_rom.sv
// Combinational lookup of the expected {carry, result} for a vector index.
module bist_golden_rom
  import alu_bist_pkg::*;
(
  input  logic [VEC_IDX_W-1:0] idx_i,
  output logic [RES_W-1:0]     expected_o
);

  // Pure table read; no state.
  always_comb begin
    expected_o = GOLDEN_TABLE[idx_i].expected;
  end

endmodule

// File: rtl/alu_bist_scheduler.sv
// Periodic / on-demand self-test scheduler for the primary ALU. Freezes the
// execute stage, steps the ALU through the golden vectors, retries a failing
// session and retires the primary ALU to the spare on a persistent failure.
module alu_bist_scheduler
  import alu_bist_pkg::*;
#(
  parameter int TEST_INTERVAL = DEF_TEST_INTERVAL,
  parameter int NUM_VEC       = DEF_NUM_VEC,
  parameter int MAX_RETRY     = DEF_MAX_RETRY
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 test_req,
  input  logic                 stall_grant,
  input  logic [31:0]          primary_res,
  input  logic                 primary_carry,
  output logic                 stall_req,
  output logic                 test_en,
  output logic [VEC_IDX_W-1:0] test_counter,
  output logic                 use_spare,
  output logic                 fault_flag,
  output logic                 test_done,
  output logic [VEC_IDX_W-1:0] fail_vec
);

  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [VEC_IDX_W-1:0] LAST_VEC  = VEC_IDX_W'(NUM_VEC - 1);
  localparam logic [TIMER_W-1:0]   TIMER_EXP = TIMER_W'(TEST_INTERVAL);
  localparam logic [RETRY_W-1:0]   RETRY_MAX = RETRY_W'(MAX_RETRY);

  logic [1:0]           rst_sync_q;
  logic                 rst_n_int;
  bist_state_e          state_q;
  logic [TIMER_W-1:0]   timer_q;
  logic [VEC_IDX_W-1:0] counter_q;
  logic [RETRY_W-1:0]   retry_q;
  logic                 mismatch_q;
  logic                 stall_req_q;
  logic                 test_en_q;
  logic                 use_spare_q;
  logic                 fault_q;
  logic                 done_q;
  logic [VEC_IDX_W-1:0] fail_vec_q;
  logic [RES_W-1:0]     golden_exp;
  logic                 vec_mismatch;

  // Reset asserts asynchronously, releases two clocks after rst rises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync_q <= 2'b00;
    else      rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n_int = rst_sync_q[1];

  bist_golden_rom u_rom (
    .idx_i      (counter_q),
    .expected_o (golden_exp)
  );

  assign vec_mismatch = ({primary_carry, primary_res} != golden_exp);

  // Session sequencing; all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      counter_q   <= '0;
      retry_q     <= '0;
      mismatch_q  <= 1'b0;
      stall_req_q <= 1'b0;
      test_en_q   <= 1'b0;
      use_spare_q <= 1'b0;
      fault_q     <= 1'b0;
      done_q      <= 1'b0;
      fail_vec_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Expiry and request collapse into a single start.
          if (test_req || (timer_q == TIMER_EXP)) begin
            state_q     <= ST_REQ;
            timer_q     <= '0;
            stall_req_q <= 1'b1;
          end else begin
            timer_q <= timer_q + TIMER_W'(1);
          end
        end
        ST_REQ: begin
          if (stall_grant) begin
            state_q    <= ST_RUN;
            test_en_q  <= 1'b1;
            counter_q  <= '0;
            mismatch_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (!stall_grant) begin
            // Execute stage reclaimed: drop the partial session, ask again.
            state_q    <= ST_REQ;
            test_en_q  <= 1'b0;
            counter_q  <= '0;
            mismatch_q <= 1'b0;
          end else begin
            if (vec_mismatch && !mismatch_q) begin
              mismatch_q <= 1'b1;
              fail_vec_q <= counter_q;
            end
            if (counter_q == LAST_VEC) begin
              state_q   <= ST_EVAL;
              test_en_q <= 1'b0;
              counter_q <= '0;
            end else begin
              counter_q <= counter_q + VEC_IDX_W'(1);
            end
          end
        end
        ST_EVAL: begin
          if (!mismatch_q) begin
            done_q      <= 1'b1;
            retry_q     <= '0;
            stall_req_q <= 1'b0;
            state_q     <= ST_IDLE;
          end else if (retry_q < RETRY_MAX) begin
            retry_q    <= retry_q + RETRY_W'(1);
            mismatch_q <= 1'b0;
            state_q    <= ST_REQ;
          end else begin
            done_q      <= 1'b1;
            fault_q     <= 1'b1;
            use_spare_q <= 1'b1;
            stall_req_q <= 1'b0;
            state_q     <= ST_FAULT;
          end
        end
        ST_FAULT: begin
          state_q <= ST_FAULT;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign stall_req    = stall_req_q;
  assign test_en      = test_en_q;
  assign test_counter = counter_q;
  assign use_spare    = use_spare_q;
  assign fault_flag   = fault_q;
  assign test_done    = done_q;
  assign fail_vec     = fail_vec_q;

endmodule

// File: tb/tb_alu_bist_scheduler.sv
// Directed bench for alu_bist_scheduler: a table of fault-injection sessions
// plus hand-written sequences for timing, grant loss, coincident start and
// mid-session reset.
module tb_alu_bist_scheduler;
  import alu_bist_pkg::*;

  localparam int TI = 15;
  // Two synchronizer clocks plus TEST_INTERVAL+1 idle clocks.
  localparam int FIRST_STALL = 2 + TI + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        test_req = 1'b0;
  logic        stall_grant = 1'b1;
  logic [31:0] primary_res;
  logic        primary_carry;
  logic        stall_req;
  logic        test_en;
  logic [2:0]  test_counter;
  logic        use_spare;
  logic        fault_flag;
  logic        test_done;
  logic [2:0]  fail_vec;

  int n_checks = 0;
  int n_fail = 0;
  int done_total = 0;
  int sess_total = 0;
  int sess_base = 0;
  int done_base = 0;
  int sidx;
  logic flip;
  logic [7:0] bad_s1 = 8'h00;
  logic [7:0] bad_s2 = 8'h00;

  typedef struct {
    logic [7:0] s1;
    logic [7:0] s2;
    int         exp_done;
    int         exp_sess;
    logic       exp_fault;
    logic       exp_spare;
    logic [2:0] exp_fv;
  } vec_t;

  vec_t tbl [6];

  alu_bist_scheduler #(
    .TEST_INTERVAL (TI),
    .NUM_VEC       (8),
    .MAX_RETRY     (1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .test_req      (test_req),
    .stall_grant   (stall_grant),
    .primary_res   (primary_res),
    .primary_carry (primary_carry),
    .stall_req     (stall_req),
    .test_en       (test_en),
    .test_counter  (test_counter),
    .use_spare     (use_spare),
    .fault_flag    (fault_flag),
    .test_done     (test_done),
    .fail_vec      (fail_vec)
  );

  always #5 clk = ~clk;

  // Behavioural ALU working from the table operands only.
  function automatic logic [32:0] alu_ref(input logic [2:0] idx);
    logic [31:0] a;
    logic [31:0] b;
    logic [32:0] r;
    a = GOLDEN_TABLE[idx].op_a;
    b = GOLDEN_TABLE[idx].op_b;
    case (GOLDEN_TABLE[idx].op)
      ALU_ADD: r = {1'b0, a} + {1'b0, b};
      ALU_SUB: r = {(a < b), a - b};
      ALU_AND: r = {1'b0, a & b};
      ALU_OR:  r = {1'b0, a | b};
      ALU_XOR: r = {1'b0, a ^ b};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Primary ALU model with result bit 0 flipped on selected vectors/sessions.
  always_comb begin
    sidx = sess_total - sess_base;
    flip = 1'b0;
    if (sidx == 1)      flip = bad_s1[test_counter];
    else if (sidx == 2) flip = bad_s2[test_counter];
    {primary_carry, primary_res} = alu_ref(test_counter) ^ {32'b0, flip};
  end

  always @(posedge test_en) sess_total <= sess_total + 1;

  always @(posedge clk) if (test_done === 1'b1) done_total <= done_total + 1;

  function automatic logic [10:0] outs();
    return {stall_req, test_en, test_counter, use_spare, fault_flag, test_done, fail_vec};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    test_req = 1'b0;
    #1;
    check("reset_outputs_zero", 64'(outs()), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic pulse_req();
    @(negedge clk);
    test_req = 1'b1;
    @(negedge clk);
    test_req = 1'b0;
  endtask

  task automatic edges_until_stall(output int n);
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (stall_req) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (test_done) begin
        seen = 1'b1;
        break;
      end
    end
    check({name, "_done_seen"}, 64'(seen), 64'd1);
  endtask

  initial begin
    int n;
    int ten;
    int cnt;
    int first;
    int second;
    int done_at;
    int sess_snap;
    bit seq_ok;
    bit got_done;
    bit found;
    bit prev;

    tbl[0] = '{s1: 8'h00, s2: 8'h00, exp_done: 1, exp_sess: 1, exp_fault: 1'b0, exp_spare: 1'b0, exp_fv: 3'd0};
    tbl[1] = '{s1: 8'h08, s2: 8'h08, exp_done: 1, exp_sess: 2, exp_fault: 1'b1, exp_spare: 1'b1, exp_fv: 3'd3};
    tbl[2] = '{s1: 8'h08, s2: 8'h00, exp_done: 1, exp_sess: 2, exp_fault: 1'b0, exp_spare: 1'b0, exp_fv: 3'd3};
    tbl[3] = '{s1: 8'hA0, s2: 8'hA0, exp_done: 1, exp_sess: 2, exp_fault: 1'b1, exp_spare: 1'b1, exp_fv: 3'd5};
    tbl[4] = '{s1: 8'h81, s2: 8'h40, exp_done: 1, exp_sess: 2, exp_fault: 1'b1, exp_spare: 1'b1, exp_fv: 3'd6};
    tbl[5] = '{s1: 8'h80, s2: 8'h00, exp_done: 1, exp_sess: 2, exp_fault: 1'b0, exp_spare: 1'b0, exp_fv: 3'd7};

    // Periodic start timing and a clean session.
    bad_s1 = 8'h00;
    bad_s2 = 8'h00;
    stall_grant = 1'b1;
    do_reset();
    done_base = done_total;
    edges_until_stall(n);
    check("s1_first_stall_cycle", 64'(n), 64'(FIRST_STALL));
    ten = 0;
    seq_ok = 1'b1;
    got_done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (test_done) begin
        got_done = 1'b1;
        break;
      end
      if (test_en) begin
        if (test_counter != 3'(ten)) seq_ok = 1'b0;
        ten++;
      end else if (test_counter != 3'd0) begin
        seq_ok = 1'b0;
      end
    end
    check("s1_done_seen", 64'(got_done), 64'd1);
    check("s1_test_en_cycles", 64'(ten), 64'd8);
    check("s1_counter_sequence", 64'(seq_ok), 64'd1);
    repeat (2) @(negedge clk);
    check("s1_done_count", 64'(done_total - done_base), 64'd1);
    check("s1_spare_fault", 64'({use_spare, fault_flag}), 64'd0);

    // Fault-injection table: on-demand sessions with per-session corruption.
    for (int k = 0; k < 6; k++) begin
      bad_s1 = tbl[k].s1;
      bad_s2 = tbl[k].s2;
      stall_grant = 1'b1;
      do_reset();
      sess_base = sess_total;
      done_base = done_total;
      repeat (2) @(negedge clk);
      pulse_req();
      wait_done($sformatf("tbl%0d", k));
      repeat (2) @(negedge clk);
      check($sformatf("tbl%0d_done_count", k), 64'(done_total - done_base), 64'(tbl[k].exp_done));
      check($sformatf("tbl%0d_sessions", k), 64'(sess_total - sess_base), 64'(tbl[k].exp_sess));
      check($sformatf("tbl%0d_fault_flag", k), 64'(fault_flag), 64'(tbl[k].exp_fault));
      check($sformatf("tbl%0d_use_spare", k), 64'(use_spare), 64'(tbl[k].exp_spare));
      check($sformatf("tbl%0d_fail_vec", k), 64'(fail_vec), 64'(tbl[k].exp_fv));
      if (tbl[k].exp_fault) begin
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
          @(negedge clk);
          test_req = (i == 5);
          if (stall_req || test_en) cnt++;
        end
        test_req = 1'b0;
        check($sformatf("tbl%0d_quiet_after_fault", k), 64'(cnt), 64'd0);
      end
    end

    // Late grant, then grant lost at vector 4 of a session that had a mismatch.
    bad_s1 = 8'h04;
    bad_s2 = 8'h00;
    stall_grant = 1'b0;
    do_reset();
    sess_base = sess_total;
    done_base = done_total;
    repeat (2) @(negedge clk);
    pulse_req();
    check("s4_stall_req_raised", 64'(stall_req), 64'd1);
    repeat (5) @(negedge clk);
    check("s4_waiting_for_grant", 64'({stall_req, test_en}), 64'h2);
    stall_grant = 1'b1;
    @(posedge clk);
    #1;
    check("s4_test_en_after_grant", 64'({test_en, test_counter}), 64'h8);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (test_counter == 3'd4) begin
        found = 1'b1;
        break;
      end
    end
    check("s4_reached_vec4", 64'(found), 64'd1);
    stall_grant = 1'b0;
    @(posedge clk);
    #1;
    check("s4_abort_state", 64'({stall_req, test_en, test_counter}), 64'h10);
    @(negedge clk);
    check("s4_no_done_on_abort", 64'(done_total - done_base), 64'd0);
    stall_grant = 1'b1;
    @(posedge clk);
    #1;
    check("s4_restart_at_zero", 64'({test_en, test_counter}), 64'h8);
    wait_done("s4");
    repeat (2) @(negedge clk);
    check("s4_done_count", 64'(done_total - done_base), 64'd1);
    check("s4_sessions", 64'(sess_total - sess_base), 64'd2);
    check("s4_spare_fault", 64'({use_spare, fault_flag}), 64'd0);

    // Request coincides with timer expiry: one session, timer restarts.
    bad_s1 = 8'h00;
    bad_s2 = 8'h00;
    stall_grant = 1'b1;
    do_reset();
    sess_base = sess_total;
    done_base = done_total;
    first = -1;
    second = -1;
    done_at = -1;
    sess_snap = -1;
    prev = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (stall_req && !prev) begin
        if (first < 0)       first = i;
        else if (second < 0) second = i;
      end
      prev = stall_req;
      if (test_done && done_at < 0) done_at = i;
      if (i == 40) sess_snap = sess_total - sess_base;
      test_req = (i == FIRST_STALL - 1);
    end
    test_req = 1'b0;
    check("s5_first_stall", 64'(first), 64'(FIRST_STALL));
    check("s5_done_cycle", 64'(done_at), 64'(FIRST_STALL + 10));
    check("s5_sessions", 64'(sess_snap), 64'd1);
    check("s5_next_stall", 64'(second), 64'(FIRST_STALL + 10 + TI + 1));

    // Reset in the middle of a session.
    bad_s1 = 8'h00;
    bad_s2 = 8'h00;
    stall_grant = 1'b1;
    do_reset();
    done_base = done_total;
    repeat (2) @(negedge clk);
    pulse_req();
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (test_counter == 3'd5) begin
        found = 1'b1;
        break;
      end
    end
    check("s6_reached_vec5", 64'(found), 64'd1);
    rst = 1'b0;
    #1;
    check("s6_outputs_zero_in_reset", 64'(outs()), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    edges_until_stall(n);
    check("s6_restart_cycle", 64'(n), 64'(FIRST_STALL));
    check("s6_no_done", 64'(done_total - done_base), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
